// File: rtl/subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so the later divider can reuse it.
package subtractor_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for the serial subtractor.
// master drives the operands, slave returns status and result.
interface serial_subtractor_if
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out
    );

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - borrow_in.
// Port order follows the full_adder cell.
module full_subtractor (
    output logic diff,
    output logic borrow_out,
    input  logic x,
    input  logic y,
    input  logic borrow_in
);

    // Difference bit and borrow propagation
    always_comb begin
        diff       = x ^ y ^ borrow_in;
        borrow_out = (~x & y) | (~(x ^ y) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// A single full_subtractor cell is reused for every bit.
module serial_subtractor
    import subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    serial_subtractor_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-2:0] res_q, res_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             diff;
    logic             br_nx;
    logic             accept;

    full_subtractor u_fs (
        .diff       (diff),
        .borrow_out (br_nx),
        .x          (a_q[0]),
        .y          (b_q[0]),
        .borrow_in  (br_q)
    );

    // Next-state, datapath shift and result capture
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;
        accept  = bus.start &&
                  (state_q == ST_IDLE || state_q == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_nx;
                res_d = (WIDTH-1)'({diff, res_q} >> 1);
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                    d_d     = {diff, res_q};
                    bout_d  = br_nx;
                end
            end
            ST_DONE: begin
                state_d = bus.start ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            a_d   = bus.a;
            b_d   = bus.b;
            br_d  = bus.b_in;
            res_d = '0;
            cnt_d = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy  = (state_q == ST_RUN);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.d     = d_q;
    assign bus.b_out = bout_q;

endmodule
